// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and default timing.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } db_state_e;

  // 10 ms at 100 MHz
  localparam int DEFAULT_STABLE_CYCLES = 1000000;
  localparam int DEFAULT_SYNC_STAGES   = 2;

endpackage

// File: rtl/level_synchronizer.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module level_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("level_synchronizer: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button: synchronise, then require STABLE_CYCLES steady cycles
// before the registered db_level follows.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic db_level,
  output logic db_busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("button_debouncer: STABLE_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debouncer: SYNC_STAGES must be >= 2");
  end

  logic             sync_in;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;

  level_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (sync_in)
  );

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE_LOW;
      cnt      <= '0;
      db_level <= 1'b0;
      db_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE_LOW: begin
          db_level <= 1'b0;
          if (sync_in) begin
            state   <= WAIT_HIGH;
            cnt     <= CNT_ONE;
            db_busy <= 1'b1;
          end else begin
            cnt     <= '0;
            db_busy <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          // A revert takes priority over reaching the threshold.
          if (!sync_in) begin
            state    <= IDLE_LOW;
            cnt      <= '0;
            db_level <= 1'b0;
            db_busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= STABLE_HIGH;
            cnt      <= '0;
            db_level <= 1'b1;
            db_busy  <= 1'b0;
          end else begin
            cnt      <= cnt + CNT_ONE;
            db_level <= 1'b0;
            db_busy  <= 1'b1;
          end
        end
        STABLE_HIGH: begin
          db_level <= 1'b1;
          if (!sync_in) begin
            state   <= WAIT_LOW;
            cnt     <= CNT_ONE;
            db_busy <= 1'b1;
          end else begin
            cnt     <= '0;
            db_busy <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (sync_in) begin
            state    <= STABLE_HIGH;
            cnt      <= '0;
            db_level <= 1'b1;
            db_busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE_LOW;
            cnt      <= '0;
            db_level <= 1'b0;
            db_busy  <= 1'b0;
          end else begin
            cnt      <= cnt + CNT_ONE;
            db_level <= 1'b1;
            db_busy  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE_LOW;
          cnt      <= '0;
          db_level <= 1'b0;
          db_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Debounces a raw mechanical push-button or switch input.
- Synchronises the input into the clk domain and filters contact bounce with a stability counter and a 4-state FSM.
- Produces a clean registered level, db_level, that drives the level input of the downstream edge-detector stage directly.
- Sits between board I/O and the edge-detection and pulse logic.

Parameters:
- STABLE_CYCLES, default 1000000: consecutive synchronised cycles the input must hold a new value before db_level follows. 10 ms at 100 MHz. Must be >= 2; elaboration error otherwise.
- SYNC_STAGES, default 2: flip-flop depth of the input synchroniser. Must be >= 2.
- CNT_W, default $clog2(STABLE_CYCLES+1): stability counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_raw  input  1  raw, asynchronous, bouncy button level.
- db_level  output  1  debounced level, registered; feeds the edge detector.
- db_busy  output  1  high while the FSM is in a WAIT state, i.e. a candidate transition is being qualified.

Behaviour:
- Reset is asynchronous and active-low on reset_n, clocked on clk.
- While reset_n=0:
  - all synchroniser flops = 0
  - state = IDLE_LOW, cnt = 0
  - db_level = 0, db_busy = 0
  These take effect immediately, not at the next clk edge.
- Synchroniser: chain of SYNC_STAGES flops; sync_in = last stage.
- FSM states: IDLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - sync_in=1 -> WAIT_HIGH, cnt<=1.
  - Otherwise stay, cnt<=0.
- WAIT_HIGH:
  - sync_in=0 -> IDLE_LOW, cnt<=0 (bounce rejected).
  - sync_in=1 and cnt==STABLE_CYCLES-1 -> STABLE_HIGH, cnt<=0.
  - sync_in=1 otherwise -> cnt<=cnt+1.
- STABLE_HIGH: mirror of IDLE_LOW (sync_in=0 -> WAIT_LOW, cnt<=1).
- WAIT_LOW: mirror of WAIT_HIGH.
  - sync_in=1 -> STABLE_HIGH.
  - Qualified low -> IDLE_LOW.
- Outputs, both registered (registered next-state decode; no combinational path from btn_raw):
  - db_level = 1 in STABLE_HIGH and WAIT_LOW; 0 in IDLE_LOW and WAIT_HIGH.
  - db_busy = 1 in WAIT_HIGH and WAIT_LOW.
- Latency: db_level changes on clk edge number SYNC_STAGES+STABLE_CYCLES, counting the first edge that samples the new btn_raw value as edge 1. Input must remain stable throughout.
- Glitch rejection: any excursion of sync_in shorter than STABLE_CYCLES cycles leaves db_level unchanged.
- Counter:
  - Never exceeds STABLE_CYCLES-1; no wrap-around possible.
  - Clears on every return to a stable state.
- Simultaneous events: the counter reaching threshold and sync_in reverting in the same cycle -> revert wins (returns to the prior stable state).
- Illegal or unused state encodings -> IDLE_LOW next cycle, cnt<=0.
- Reset mid-qualification: progress is discarded. After release, a still-held button requires the full latency again from the first sampling edge.

Decomposition:
- Shared package/include debounce_pkg holds:
  - state encodings (IDLE_LOW=2'd0, WAIT_HIGH=2'd1, STABLE_HIGH=2'd2, WAIT_LOW=2'd3)
  - default STABLE_CYCLES and SYNC_STAGES constants
- One sub-module, level_synchronizer: parameter STAGES; ports clk, reset_n, d, q. Reusable for other asynchronous inputs.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn_raw 0->1 and held. db_level rises exactly on edge 6; db_busy high for edges 3-5 only.
- Short glitch: btn_raw high for 3 cycles, then low. db_level stays 0 throughout; db_busy pulses 3 cycles; FSM returns to IDLE_LOW.
- Bouncy press: btn_raw pattern 1,0,1,1,0,1,1,1,1,1… db_level rises only after the final run of 4 synchronised 1s, i.e. 6 edges after the run starts.
- Clean release: from STABLE_HIGH, btn_raw 1->0 and held. db_level falls on edge 6; a 2-cycle low glitch during STABLE_HIGH leaves db_level=1.
- Reset mid-operation: assert reset_n=0 during WAIT_HIGH with cnt=2. db_level=0 and db_busy=0 immediately. Release with btn_raw held high -> db_level rises 6 edges after release.
- Downstream integration: feed db_level into the edge detector. Exactly one rising-edge pulse per qualified press and one falling-edge pulse per qualified release, for the bouncy stimulus above.
